snake_link: RTL and testbench
=============================

// Module: snake_link
// PURPOSE
//  Parametrised board-to-board link for SnakeWars: per game tick, sends local snake directions over UART 8N1
//  and receives the remote board's directions. Supports NP players per side, sequence-tagged frames,
//  error reporting and link-loss timeout. Sits between the mouse/direction logic and the move engine.
// PARAMETERS
//  CLK_HZ        75_000_000  system clock frequency
//  BAUD          115_200     UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, must be >= 4)
//  NP            1           players per side (1..8); data bytes per frame
//  TIMEOUT_TICKS 8           send ticks without a valid frame before link_lost asserts (>= 1)
// PORTS
//  clk         in   1        system clock; the only clock
//  rst         in   1        synchronous, active-high reset
//  rx          in   1        UART receive line (asynchronous; 2-FF synchronised inside)
//  send        in   1        game-tick pulse; starts one TX frame
//  dir_local   in   NPx2     direction[NP], local players' directions
//  tx          out  1        UART transmit line
//  dir_remote  out  NPx2     direction[NP], last accepted remote directions
//  rcvdir      out  1        1-cycle pulse: new valid frame accepted
//  com_err     out  1        1-cycle pulse: framing, checksum or sequence error
//  link_lost   out  1        level: TIMEOUT_TICKS sends since last valid frame
//  tx_busy     out  1        level: TX frame in progress
// BEHAVIOUR
//  Reset: tx=1, dir_remote[i]=DIR_RESET, rcvdir=0, com_err=0, link_lost=0, tx_busy=0, seq=0, RX->HUNT, TX->IDLE.
//  Frame: SYNC_BYTE (8'hA5), NP data bytes {seq[3:0],2'b00,dir[1:0]}, then checksum (XOR of data bytes) if enabled.
//  Bytes 8N1, LSB first, back-to-back, no idle bits between bytes.
//  TX FSM: IDLE -send-> SYNC -> DATA(idx 0..NP-1) -> [CSUM] -> IDLE.
//   On accepted send, dir_local latched and seq used, then seq+1 (4-bit wrap 15->0). tx_busy=1 from next cycle
//   until end of last stop bit. First start bit drives tx the cycle after send.
//   send while tx_busy: ignored (no latch, no seq change); still counts toward timeout.
//  RX: start edge seen -> re-check at half bit (glitch -> abandon); sample data at bit centres;
//   stop bit sampled 0 -> framing error.
//  RX FSM: HUNT -byte==SYNC-> DATA(idx) -> [CSUM] -> CHECK -> HUNT. Non-SYNC bytes in HUNT silently dropped.
//   CHECK: all NP seq fields equal and checksum match -> dir_remote updated, rcvdir pulse same cycle
//   (1 cycle after last stop-bit sample); else com_err pulse, dir_remote held.
//   Framing error in any state: com_err pulse, -> HUNT. Received seq not compared to previous frame (gaps legal).
//  Timeout: 4-bit+ counter of send pulses, cleared on valid frame; link_lost=1 when count>=TIMEOUT_TICKS
//   (saturates); link_lost clears in the rcvdir cycle. send and valid frame same cycle: clear wins, count=0.
//  rst mid-frame: everything returns to reset values next cycle; partial frame discarded.
// CONFIGURATION
//  SNAKE_LINK_CHECKSUM_EN defined: checksum byte transmitted and verified; frame = NP+2 bytes.
//  Not defined: no checksum byte sent or expected, frame = NP+1 bytes; errors only framing/sequence.
//  Both ends must be built with the same setting.
// STRUCTURE
//  snake_pkg: direction (existing), DIR_RESET, SYNC_BYTE, link_tx_state_e, link_rx_state_e.
//  Sub-module uart_byte: shared baud counter-free byte TX/RX engines (tx_start/tx_done, rx_valid/rx_ferr);
//  snake_link holds the frame FSMs, seq, checksum and timeout logic.
// TESTING (CLK_HZ=800, BAUD=100 -> 8 clk/bit, NP=2, TIMEOUT_TICKS=3, checksum enabled, tx looped to rx)
//  1 dir_local={2'd0,2'd3}, one send -> tx bytes A5,00,03,03; rcvdir 1 pulse; dir_remote={0,3}; no com_err.
//  2 Inject A5,10,13,04 (bad checksum) -> com_err 1 pulse, no rcvdir, dir_remote unchanged.
//  3 Inject 12,34 then A5,21,22,03 -> garbage ignored, rcvdir, dir_remote={1,2}, com_err never.
//  4 Inject A5,10,23,33 (seq mismatch) -> com_err; stop bit forced 0 mid-frame -> com_err, RX back to HUNT.
//  5 rx idle, 3 send pulses -> link_lost=1 after 3rd; valid frame -> link_lost=0 with rcvdir.
//  6 send again while tx_busy -> frame unchanged, seq advances by 1 only; rst mid-byte -> tx=1 next cycle, outputs reset.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared SnakeWars types: player directions, link framing constants and link FSM state encodings.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } direction_e;

  localparam direction_e DIR_RESET = DIR_RIGHT;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {TX_IDLE, TX_SYNC, TX_DATA, TX_CSUM} link_tx_state_e;
  typedef enum logic [1:0] {RX_HUNT, RX_DATA, RX_CSUM, RX_CHECK} link_rx_state_e;
  typedef enum logic [1:0] {URX_IDLE, URX_START, URX_BITS, URX_STOP} uart_rx_state_e;

  function automatic logic [7:0] data_byte(input logic [3:0] seq, input direction_e dir);
    return {seq, 2'b00, dir};
  endfunction

endpackage

// File: rtl/uart_byte.sv
// 8N1 byte engines: TX loads on tx_start (accepted when idle or in the last stop-bit cycle) and starts its start bit next cycle;
// RX samples at bit centres after a 2-FF sync and pulses rx_valid/rx_ferr in the stop-bit sample cycle, no backpressure.
module uart_byte
  import snake_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx,
  output logic       tx_done,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [9:0]       tx_shift_q, tx_shift_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;
  logic             tx_act_q, tx_act_d;

  logic             rx_meta_q, rx_sync_q;
  uart_rx_state_e   rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;

  assign tx      = tx_shift_q[0];
  assign tx_done = tx_act_q && (tx_bit_q == 4'd9) && (tx_cnt_q == LAST);
  assign rx_byte = rx_shift_q;

  // Shift register holds {stop, data, start}; reloading on tx_done keeps bytes back-to-back.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_act_d   = tx_act_q;
    if (tx_act_q) begin
      if (tx_cnt_q == LAST) begin
        tx_cnt_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_act_d = 1'b0;
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end
    if (tx_start && (!tx_act_q || tx_done)) begin
      tx_shift_d = {1'b1, tx_byte, 1'b0};
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_act_d   = 1'b1;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      URX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = URX_START;
          rx_cnt_d   = '0;
        end
      end
      URX_START: begin
        if (rx_cnt_q == HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? URX_IDLE : URX_BITS;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      URX_BITS: begin
        if (rx_cnt_q == LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = URX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      URX_STOP: begin
        if (rx_cnt_q == LAST) begin
          rx_valid   = rx_sync_q;
          rx_ferr    = !rx_sync_q;
          rx_state_d = URX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = URX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_act_q   <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= URX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_act_q   <= tx_act_d;
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: rtl/snake_link.sv
// SnakeWars board link: one sequence-tagged UART frame per send, remote frames checked and applied 1 cycle after the last stop sample.
// Sends arriving mid-frame are dropped (still counted for timeout); SNAKE_LINK_CHECKSUM_EN adds an XOR checksum byte.
module snake_link
  import snake_pkg::*;
#(
  parameter int CLK_HZ        = 75_000_000,
  parameter int BAUD          = 115_200,
  parameter int NP            = 1,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       send,
  input  direction_e dir_local [NP],
  output logic       tx,
  output direction_e dir_remote [NP],
  output logic       rcvdir,
  output logic       com_err,
  output logic       link_lost,
  output logic       tx_busy
);

  localparam int IDX_W  = (NP > 1) ? $clog2(NP) : 1;
  localparam int TO_RAW = $clog2(TIMEOUT_TICKS + 1);
  localparam int TO_W   = (TO_RAW > 4) ? TO_RAW : 4;

  logic       tx_start, tx_done, rx_valid, rx_ferr;
  logic [7:0] tx_byte, rx_byte;

  uart_byte #(
    .CLKS_PER_BIT(CLK_HZ / BAUD)
  ) u_uart (
    .clk     (clk),
    .rst     (rst),
    .tx_start(tx_start),
    .tx_byte (tx_byte),
    .tx      (tx),
    .tx_done (tx_done),
    .rx      (rx),
    .rx_byte (rx_byte),
    .rx_valid(rx_valid),
    .rx_ferr (rx_ferr)
  );

  link_tx_state_e tx_state_q, tx_state_d;
  logic [IDX_W-1:0] tx_idx_q, tx_idx_d, tx_idx_nxt;
  direction_e       tx_dir_q [NP];
  direction_e       tx_dir_d [NP];
  direction_e       nxt_dir;
  logic [3:0]       seq_q, seq_d, tx_fseq_q, tx_fseq_d;

  link_rx_state_e rx_state_q, rx_state_d;
  logic [IDX_W-1:0] rx_idx_q, rx_idx_d;
  direction_e       rx_buf_q [NP];
  direction_e       rx_buf_d [NP];
  direction_e       dir_remote_q [NP];
  direction_e       dir_remote_d [NP];
  logic [3:0]       rx_seq0_q, rx_seq0_d;
  logic             rx_seq_ok_q, rx_seq_ok_d;
  logic             frame_ok;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
`ifdef SNAKE_LINK_CHECKSUM_EN
  logic [7:0]       tx_csum_q, tx_csum_d, rx_csum_q, rx_csum_d;
  logic             rx_csum_ok_q, rx_csum_ok_d;
`endif

  assign tx_busy    = (tx_state_q != TX_IDLE);
  assign tx_idx_nxt = tx_idx_q + IDX_W'(1);
  assign dir_remote = dir_remote_q;
  assign link_lost  = (to_cnt_q >= TO_W'(TIMEOUT_TICKS)) && !rcvdir;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_idx_d   = tx_idx_q;
    tx_dir_d   = tx_dir_q;
    seq_d      = seq_q;
    tx_fseq_d  = tx_fseq_q;
`ifdef SNAKE_LINK_CHECKSUM_EN
    tx_csum_d  = tx_csum_q;
`endif
    tx_start   = 1'b0;
    tx_byte    = SYNC_BYTE;
    nxt_dir    = tx_dir_q[0];
    for (int i = 0; i < NP; i++) begin
      if (IDX_W'(i) == tx_idx_nxt) nxt_dir = tx_dir_q[i];
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (send) begin
          tx_start   = 1'b1;
          tx_dir_d   = dir_local;
          tx_fseq_d  = seq_q;
          seq_d      = seq_q + 4'd1;
          tx_state_d = TX_SYNC;
        end
      end
      TX_SYNC: begin
        if (tx_done) begin
          tx_start   = 1'b1;
          tx_byte    = data_byte(tx_fseq_q, tx_dir_q[0]);
          tx_idx_d   = '0;
          tx_state_d = TX_DATA;
`ifdef SNAKE_LINK_CHECKSUM_EN
          tx_csum_d  = tx_byte;
`endif
        end
      end
      TX_DATA: begin
        if (tx_done) begin
          if (tx_idx_q == IDX_W'(NP - 1)) begin
`ifdef SNAKE_LINK_CHECKSUM_EN
            tx_start   = 1'b1;
            tx_byte    = tx_csum_q;
            tx_state_d = TX_CSUM;
`else
            tx_state_d = TX_IDLE;
`endif
          end else begin
            tx_start  = 1'b1;
            tx_byte   = data_byte(tx_fseq_q, nxt_dir);
            tx_idx_d  = tx_idx_nxt;
`ifdef SNAKE_LINK_CHECKSUM_EN
            tx_csum_d = tx_csum_q ^ tx_byte;
`endif
          end
        end
      end
      TX_CSUM: if (tx_done) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Frame acceptance: every data byte must carry the first byte's seq; gaps between frames are legal.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_idx_d     = rx_idx_q;
    rx_buf_d     = rx_buf_q;
    dir_remote_d = dir_remote_q;
    rx_seq0_d    = rx_seq0_q;
    rx_seq_ok_d  = rx_seq_ok_q;
`ifdef SNAKE_LINK_CHECKSUM_EN
    rx_csum_d    = rx_csum_q;
    rx_csum_ok_d = rx_csum_ok_q;
    frame_ok     = rx_seq_ok_q && rx_csum_ok_q;
`else
    frame_ok     = rx_seq_ok_q;
`endif
    rcvdir       = 1'b0;
    com_err      = 1'b0;
    case (rx_state_q)
      RX_HUNT: begin
        if (rx_valid && (rx_byte == SYNC_BYTE)) begin
          rx_state_d  = RX_DATA;
          rx_idx_d    = '0;
          rx_seq_ok_d = 1'b1;
`ifdef SNAKE_LINK_CHECKSUM_EN
          rx_csum_d   = '0;
`endif
        end
      end
      RX_DATA: begin
        if (rx_valid) begin
          for (int i = 0; i < NP; i++) begin
            if (IDX_W'(i) == rx_idx_q) rx_buf_d[i] = direction_e'(rx_byte[1:0]);
          end
          if (rx_idx_q == '0) rx_seq0_d = rx_byte[7:4];
          else if (rx_byte[7:4] != rx_seq0_q) rx_seq_ok_d = 1'b0;
`ifdef SNAKE_LINK_CHECKSUM_EN
          rx_csum_d = rx_csum_q ^ rx_byte;
`endif
          if (rx_idx_q == IDX_W'(NP - 1)) begin
`ifdef SNAKE_LINK_CHECKSUM_EN
            rx_state_d = RX_CSUM;
`else
            rx_state_d = RX_CHECK;
`endif
          end else begin
            rx_idx_d = rx_idx_q + IDX_W'(1);
          end
        end
      end
      RX_CSUM: begin
`ifdef SNAKE_LINK_CHECKSUM_EN
        if (rx_valid) begin
          rx_csum_ok_d = (rx_byte == rx_csum_q);
          rx_state_d   = RX_CHECK;
        end
`else
        rx_state_d = RX_HUNT;
`endif
      end
      RX_CHECK: begin
        if (frame_ok) begin
          dir_remote_d = rx_buf_q;
          rcvdir       = 1'b1;
        end else begin
          com_err = 1'b1;
        end
        rx_state_d = RX_HUNT;
      end
      default: rx_state_d = RX_HUNT;
    endcase
    if (rx_ferr) begin
      com_err    = 1'b1;
      rx_state_d = RX_HUNT;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (rcvdir) to_cnt_d = '0;
    else if (send && (to_cnt_q < TO_W'(TIMEOUT_TICKS))) to_cnt_d = to_cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q   <= TX_IDLE;
      tx_idx_q     <= '0;
      tx_dir_q     <= '{default: DIR_RESET};
      seq_q        <= '0;
      tx_fseq_q    <= '0;
      rx_state_q   <= RX_HUNT;
      rx_idx_q     <= '0;
      rx_buf_q     <= '{default: DIR_RESET};
      dir_remote_q <= '{default: DIR_RESET};
      rx_seq0_q    <= '0;
      rx_seq_ok_q  <= 1'b0;
      to_cnt_q     <= '0;
`ifdef SNAKE_LINK_CHECKSUM_EN
      tx_csum_q    <= '0;
      rx_csum_q    <= '0;
      rx_csum_ok_q <= 1'b0;
`endif
    end else begin
      tx_state_q   <= tx_state_d;
      tx_idx_q     <= tx_idx_d;
      tx_dir_q     <= tx_dir_d;
      seq_q        <= seq_d;
      tx_fseq_q    <= tx_fseq_d;
      rx_state_q   <= rx_state_d;
      rx_idx_q     <= rx_idx_d;
      rx_buf_q     <= rx_buf_d;
      dir_remote_q <= dir_remote_d;
      rx_seq0_q    <= rx_seq0_d;
      rx_seq_ok_q  <= rx_seq_ok_d;
      to_cnt_q     <= to_cnt_d;
`ifdef SNAKE_LINK_CHECKSUM_EN
      tx_csum_q    <= tx_csum_d;
      rx_csum_q    <= rx_csum_d;
      rx_csum_ok_q <= rx_csum_ok_d;
`endif
    end
  end

endmodule

// File: tb/tb_snake_link.sv
// Directed bench for snake_link: 8 clk/bit, NP=2, TIMEOUT_TICKS=3, tx looped to rx or driven by the bench.
module tb_snake_link;
  import snake_pkg::*;

  localparam int NP  = 2;
  localparam int CPB = 8;
`ifdef SNAKE_LINK_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, send, loop, inj, rx, tx;
  direction_e dir_local [NP];
  direction_e dir_remote [NP];
  logic       rcvdir, com_err, link_lost, tx_busy;

  int   checks = 0, errors = 0;
  int   n_rcv = 0, n_err = 0, r0, e0;
  logic ll_at_rcv = 1'b1;

  always #5 clk = ~clk;
  assign rx = loop ? tx : inj;

  snake_link #(
    .CLK_HZ(800), .BAUD(100), .NP(NP), .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .send(send), .dir_local(dir_local),
    .tx(tx), .dir_remote(dir_remote), .rcvdir(rcvdir), .com_err(com_err),
    .link_lost(link_lost), .tx_busy(tx_busy)
  );

  always @(negedge clk) begin
    if (rcvdir) begin
      n_rcv++;
      ll_at_rcv = link_lost;
    end
    if (com_err) n_err++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_send(input logic [1:0] d0, input logic [1:0] d1);
    dir_local[0] = direction_e'(d0);
    dir_local[1] = direction_e'(d1);
    send = 1'b1;
    tick(1);
    send = 1'b0;
  endtask

  task automatic inj_byte(input logic [7:0] b, input logic stop);
    inj = 1'b0;
    tick(CPB);
    for (int k = 0; k < 8; k++) begin
      inj = b[k];
      tick(CPB);
    end
    inj = stop;
    tick(CPB);
    inj = 1'b1;
  endtask

  task automatic inj_frame(input logic [7:0] d0, input logic [7:0] d1);
    inj_byte(SYNC_BYTE, 1'b1);
    inj_byte(d0, 1'b1);
    inj_byte(d1, 1'b1);
    if (CSUM) inj_byte(d0 ^ d1, 1'b1);
    tick(20);
  endtask

  task automatic get_tx_byte(output logic [7:0] b, output logic ok);
    b  = '0;
    ok = 1'b0;
    for (int i = 0; i < 400 && tx !== 1'b0; i++) @(negedge clk);
    if (tx === 1'b0) begin
      tick(4);
      for (int k = 0; k < 8; k++) begin
        tick(CPB);
        b[k] = tx;
      end
      tick(CPB);
      ok = (tx === 1'b1);
    end
  endtask

  task automatic check_frame(input string tag, input logic [3:0] seq,
                             input logic [1:0] d0, input logic [1:0] d1);
    logic [7:0] exp [4];
    logic [7:0] b;
    logic       ok;
    exp[0] = 8'hA5;
    exp[1] = {seq, 2'b00, d0};
    exp[2] = {seq, 2'b00, d1};
    exp[3] = {4'h0, 2'b00, d0 ^ d1};
    for (int i = 0; i < (CSUM ? 4 : 3); i++) begin
      get_tx_byte(b, ok);
      check($sformatf("%s_frame%0d", tag, i), {31'd0, ok}, 32'd1);
      check($sformatf("%s_byte%0d", tag, i), {24'd0, b}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; loop = 1'b1; inj = 1'b1;
    dir_local[0] = DIR_UP;
    dir_local[1] = DIR_UP;
    tick(3);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_rcvdir", rcvdir, 0);
    check("rst_comerr", com_err, 0);
    check("rst_lost", link_lost, 0);
    check("rst_dir0", dir_remote[0], 1);
    check("rst_dir1", dir_remote[1], 1);
    rst = 1'b0;
    tick(2);

    // 1: loopback frame, seq 0
    r0 = n_rcv; e0 = n_err;
    do_send(2'd0, 2'd3);
    check("t1_busy", tx_busy, 1);
    check_frame("t1", 4'd0, 2'd0, 2'd3);
    tick(30);
    check("t1_rcv", n_rcv - r0, 1);
    check("t1_err", n_err - e0, 0);
    check("t1_dir0", dir_remote[0], 0);
    check("t1_dir1", dir_remote[1], 3);
    check("t1_idle", tx_busy, 0);

    // 2: bad checksum
    loop = 1'b0;
    r0 = n_rcv; e0 = n_err;
    inj_byte(8'hA5, 1'b1); inj_byte(8'h10, 1'b1); inj_byte(8'h13, 1'b1); inj_byte(8'h04, 1'b1);
    tick(20);
    check("t2_err", n_err - e0, CSUM ? 1 : 0);
    check("t2_rcv", n_rcv - r0, CSUM ? 0 : 1);
    check("t2_dir0", dir_remote[0], 0);
    check("t2_dir1", dir_remote[1], 3);

    // 3: garbage before a valid frame
    r0 = n_rcv; e0 = n_err;
    inj_byte(8'h12, 1'b1); inj_byte(8'h34, 1'b1);
    inj_byte(8'hA5, 1'b1); inj_byte(8'h21, 1'b1); inj_byte(8'h22, 1'b1); inj_byte(8'h03, 1'b1);
    tick(20);
    check("t3_rcv", n_rcv - r0, 1);
    check("t3_err", n_err - e0, 0);
    check("t3_dir0", dir_remote[0], 1);
    check("t3_dir1", dir_remote[1], 2);

    // 4: seq mismatch, then framing error mid-frame, then recovery
    r0 = n_rcv; e0 = n_err;
    inj_byte(8'hA5, 1'b1); inj_byte(8'h10, 1'b1); inj_byte(8'h23, 1'b1); inj_byte(8'h33, 1'b1);
    tick(20);
    check("t4_seq_err", n_err - e0, 1);
    check("t4_seq_rcv", n_rcv - r0, 0);
    check("t4_seq_dir0", dir_remote[0], 1);
    e0 = n_err;
    inj_byte(8'hA5, 1'b1); inj_byte(8'h31, 1'b0);
    tick(20);
    check("t4_ferr", n_err - e0, 1);
    inj_frame(8'h31, 8'h30);
    check("t4_hunt_rcv", n_rcv - r0, 1);
    check("t4_hunt_dir0", dir_remote[0], 1);
    check("t4_hunt_dir1", dir_remote[1], 0);

    // 5: link-loss timeout (2nd and 3rd sends land while busy)
    do_send(2'd2, 2'd1);
    tick(1);
    check("t5_lost1", link_lost, 0);
    do_send(2'd2, 2'd1);
    check("t5_lost2", link_lost, 0);
    do_send(2'd2, 2'd1);
    check("t5_lost3", link_lost, 1);
    for (int i = 0; i < 1000 && tx_busy; i++) tick(1);
    check("t5_txdone", tx_busy, 0);
    loop = 1'b1;
    r0 = n_rcv;
    do_send(2'd3, 2'd3);
    check("t5_lost_held", link_lost, 1);
    check_frame("t5", 4'd2, 2'd3, 2'd3);
    tick(30);
    check("t5_rcv", n_rcv - r0, 1);
    check("t5_lost_at_rcv", ll_at_rcv, 0);
    check("t5_lost_after", link_lost, 0);
    check("t5_dir0", dir_remote[0], 3);

    // 6: send while busy is ignored; seq advances once per accepted frame
    r0 = n_rcv;
    do_send(2'd1, 2'd2);
    fork
      check_frame("t6a", 4'd3, 2'd1, 2'd2);
      begin
        tick(100);
        dir_local[0] = DIR_UP;
        dir_local[1] = DIR_UP;
        send = 1'b1;
        tick(1);
        send = 1'b0;
      end
    join
    tick(30);
    check("t6_rcv", n_rcv - r0, 1);
    check("t6_dir0", dir_remote[0], 1);
    check("t6_dir1", dir_remote[1], 2);
    do_send(2'd0, 2'd0);
    check_frame("t6b", 4'd4, 2'd0, 2'd0);
    tick(30);

    // reset mid-byte
    do_send(2'd2, 2'd3);
    tick(20);
    rst = 1'b1;
    tick(1);
    check("rst2_tx", tx, 1);
    check("rst2_busy", tx_busy, 0);
    check("rst2_lost", link_lost, 0);
    check("rst2_dir0", dir_remote[0], 1);
    check("rst2_dir1", dir_remote[1], 1);
    rst = 1'b0;
    r0 = n_rcv; e0 = n_err;
    tick(120);
    check("rst2_no_rcv", n_rcv - r0, 0);
    check("rst2_no_err", n_err - e0, 0);
    do_send(2'd2, 2'd3);
    check_frame("rst2", 4'd0, 2'd2, 2'd3);
    tick(30);
    check("rst2_rcv", n_rcv - r0, 1);
    check("rst2_rdir0", dir_remote[0], 2);
    check("rst2_rdir1", dir_remote[1], 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
